// File: rtl/generic_output_ctrl.sv
// generic_output_ctrl: per-channel OFF/ON/BLINK/PWM output controller with change flags and event counter
module generic_output_ctrl #(
  parameter int   CH  = 4,
  parameter int   PW  = 4,
  parameter int   PRE = 4,
  parameter logic DS  = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [4:0]    wr_ch,
  input  logic [1:0]    wr_mode,
  input  logic [PW-1:0] wr_val,
  input  logic [CH-1:0] chg_clr,
  output logic [CH-1:0] out,
  output logic [CH-1:0] chg,
  output logic [7:0]    evt_cnt
);
  localparam int PBW = PRE > 1 ? $clog2(PRE) : 1;
  logic [PBW-1:0] pre;
  logic [PW-1:0]  slot;
  logic           tick;
  logic [CH-1:0]  nxt, prev, diff;
  assign tick = pre == PBW'(PRE - 1);
  assign diff = out ^ prev;
  // free-running prescaler and shared PWM slot counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pre  <= '0;
      slot <= '0;
    end else begin
      pre  <= tick ? '0 : pre + 1'b1;
      slot <= tick ? slot + 1'b1 : slot;
    end
  end
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [1:0]    mode;
    logic [PW-1:0] val, bcnt;
    logic          phase, hit, wrap;
    assign hit  = wr_en && wr_ch == 5'(i);
    assign wrap = bcnt == val;
    // channel configuration and blink timing; a write restarts the blink cycle
    always_ff @(posedge clk) begin
      if (rst) begin
        mode  <= 2'b00;
        val   <= '0;
        bcnt  <= '0;
        phase <= 1'b0;
      end else if (hit) begin
        mode  <= wr_mode;
        val   <= wr_val;
        bcnt  <= '0;
        phase <= 1'b0;
      end else if (tick && mode == 2'b10) begin
        bcnt  <= wrap ? '0 : bcnt + 1'b1;
        phase <= phase ^ wrap;
      end
    end
    assign nxt[i] = mode == 2'b00 ? DS :
                    mode == 2'b01 ? ~DS :
                    mode == 2'b10 ? DS ^ phase : DS ^ (slot < val);
  end
  // registered outputs; change detection compares against the previous output so reset returns are not flagged
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= {CH{DS}};
      prev    <= {CH{DS}};
      chg     <= '0;
      evt_cnt <= '0;
    end else begin
      out     <= nxt;
      prev    <= out;
      chg     <= (chg & ~chg_clr) | diff;
      evt_cnt <= evt_cnt + 8'(|diff && evt_cnt != 8'hff);
    end
  end
endmodule

// File: tb/tb_generic_output_ctrl.sv
// tb_generic_output_ctrl: randomized scoreboard bench against a time-based reference model
module tb_generic_output_ctrl;
  localparam int CH = 4, PW = 4, PRE = 4;
  logic          clk = 0, rst = 1, wr_en = 0;
  logic [4:0]    wr_ch = 0;
  logic [1:0]    wr_mode = 0;
  logic [PW-1:0] wr_val = 0;
  logic [CH-1:0] chg_clr = 0, out, chg;
  logic [7:0]    evt_cnt;
  int            checks = 0, passed = 0;
  logic          done = 0;
  typedef struct packed {logic [CH-1:0] o; logic [CH-1:0] c; logic [7:0] e;} exp_t;
  exp_t q[$];
  generic_output_ctrl #(.CH(CH), .PW(PW), .PRE(PRE), .DS(1'b0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_val(wr_val), .chg_clr(chg_clr), .out(out), .chg(chg), .evt_cnt(evt_cnt));
  always #5 clk = ~clk;
  int            e;
  int            m_mode[CH], m_val[CH], m_wt[CH];
  logic [CH-1:0] m_out, m_prev, m_chg;
  int            m_evt;
  always @(posedge clk) begin
    logic [CH-1:0] n_out;
    if (rst) begin
      e = 0; m_out = '0; m_prev = '0; m_chg = '0; m_evt = 0;
      for (int i = 0; i < CH; i++) begin m_mode[i] = 0; m_val[i] = 0; m_wt[i] = 0; end
    end else begin
      e++;
      for (int i = 0; i < CH; i++) begin
        int slot, ticks;
        slot  = ((e - 1) / PRE) % (1 << PW);
        ticks = (e - 1) / PRE - m_wt[i] / PRE;
        case (m_mode[i])
          0: n_out[i] = 1'b0;
          1: n_out[i] = 1'b1;
          2: n_out[i] = ((ticks / (m_val[i] + 1)) % 2) == 1;
          default: n_out[i] = slot < m_val[i];
        endcase
      end
      m_chg = (m_chg & ~chg_clr) | (m_out ^ m_prev);
      if (m_out != m_prev && m_evt < 255) m_evt++;
      m_prev = m_out;
      m_out  = n_out;
      if (wr_en && wr_ch < CH) begin
        m_mode[wr_ch] = wr_mode; m_val[wr_ch] = wr_val; m_wt[wr_ch] = e;
      end
    end
    q.push_back({m_out, m_chg, 8'(m_evt)});
  end
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (out === x.o && chg === x.c && evt_cnt === x.e) passed++;
      else $display("FAIL state t=%0t out=%b chg=%b evt=%0d required out=%b chg=%b evt=%0d",
                    $time, out, chg, evt_cnt, x.o, x.c, x.e);
    end
  end
  task automatic chk_rst(input string tag);
    checks++;
    if (out === '0 && chg === '0 && evt_cnt === 8'd0) passed++;
    else $display("FAIL %s reset state t=%0t out=%b chg=%b evt=%0d", tag, $time, out, chg, evt_cnt);
  endtask
  task automatic wr(input int ch, input int md, input int v, input int hold);
    wr_en = 1; wr_ch = 5'(ch); wr_mode = 2'(md); wr_val = PW'(v);
    @(negedge clk);
    wr_en = 0;
    repeat (hold) @(negedge clk);
  endtask
  initial begin
    #500000;
    if (!done) begin
      checks++;
      $display("FAIL timeout: wait expired after %0t, %0d/%0d checks passed", $time, passed, checks);
      $finish;
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk_rst("initial");
    rst = 0;
    wr(1, 1, 0, 6);
    chg_clr = 4'b0010; @(negedge clk); chg_clr = 0;
    wr(2, 2, 1, 40);
    wr(0, 3, 4, 140);
    wr(0, 3, 0, 20);
    wr(3, 3, 15, 70);
    wr(5, 1, 7, 4);
    wr(0, 1, 0, 1);
    chg_clr = 4'b0001; @(negedge clk);
    @(negedge clk); chg_clr = 0;
    wr(2, 2, 0, 9);
    rst = 1; @(negedge clk);
    chk_rst("mid-blink");
    rst = 0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom % 500) == 0;
      wr_en   = ($urandom % 12) == 0;
      wr_ch   = 5'($urandom % 7);
      wr_mode = 2'($urandom);
      wr_val  = PW'($urandom);
      chg_clr = ($urandom % 4) == 0 ? CH'($urandom) : '0;
      @(negedge clk);
    end
    rst = 0; wr_en = 0; chg_clr = 0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    done = 1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
